cam_learn_table: RTL and testbench

Associative key/value table for the L2 switch forwarding path, a successor to the plain CAM that adds a value per entry, learning with automatic slot allocation, aging, and flush. Forwarding logic issues a destination-MAC lookup each frame and a source-MAC learn each frame. Entries not refreshed within the age window are dropped automatically. Storage is register-based with a full parallel compare, sized for small depths (up to 64 entries).

---
 rtl/cam_learn_table_if.sv | 37 +++
 rtl/cam_learn_table.sv | 184 ++++++++++++++++++
 tb/tb_cam_learn_table.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_learn_table_if.sv
// Lookup, learn, aging and status signals of cam_learn_table.
// master drives requests (forwarding logic); slave is the table itself.
interface cam_learn_table_if #(
    parameter int DATA_WIDTH  = 48,
    parameter int ADDR_WIDTH  = 5,
    parameter int VALUE_WIDTH = 4
);
    logic                   lookup_valid;
    logic [DATA_WIDTH-1:0]  lookup_key;
    logic                   result_valid;
    logic                   result_hit;
    logic [ADDR_WIDTH-1:0]  result_addr;
    logic [VALUE_WIDTH-1:0] result_value;
    logic                   learn_valid;
    logic                   learn_ready;
    logic [DATA_WIDTH-1:0]  learn_key;
    logic [VALUE_WIDTH-1:0] learn_value;
    logic                   learn_done;
    logic                   learn_hit;
    logic                   learn_drop;
    logic                   age_tick;
    logic                   flush;
    logic [ADDR_WIDTH:0]    entry_count;
    logic                   full;

    modport master (
        output lookup_valid, lookup_key, learn_valid, learn_key, learn_value, age_tick, flush,
        input  result_valid, result_hit, result_addr, result_value,
               learn_ready, learn_done, learn_hit, learn_drop, entry_count, full
    );

    modport slave (
        input  lookup_valid, lookup_key, learn_valid, learn_key, learn_value, age_tick, flush,
        output result_valid, result_hit, result_addr, result_value,
               learn_ready, learn_done, learn_hit, learn_drop, entry_count, full
    );
endinterface

// File: rtl/cam_learn_table.sv
// Register-based key/value CAM with learning, lowest-free-slot allocation, flush and
// optional aging (macro CAM_AGE_EN; when undefined entries persist until flush/rst).
//
// state    | meaning
// S_IDLE   | learn_ready=1, waiting for a learn request
// S_COMMIT | write/refresh/drop decided from the compare captured at accept
module cam_learn_table #(
    parameter int DATA_WIDTH  = 48,
    parameter int ADDR_WIDTH  = 5,
    parameter int VALUE_WIDTH = 4,
    parameter int AGE_MAX     = 3
) (
    input  logic              clk,
    input  logic              rst,
    cam_learn_table_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {S_IDLE, S_COMMIT} state_t;
    state_t state_q, state_d;

    logic [DEPTH-1:0]       valid_q, valid_d, valid_view, expire;
    logic [DATA_WIDTH-1:0]  key_q   [DEPTH];
    logic [VALUE_WIDTH-1:0] value_q [DEPTH];

    logic                   lk_hit, ln_hit, ln_free;
    logic [ADDR_WIDTH-1:0]  lk_idx, ln_hit_idx, ln_free_idx;

    logic                   cap_hit, cap_free;
    logic [ADDR_WIDTH-1:0]  cap_hit_idx, cap_free_idx;
    logic [DATA_WIDTH-1:0]  cap_key;
    logic [VALUE_WIDTH-1:0] cap_value;

    logic                   accept, commit, wr_en;
    logic [ADDR_WIDTH-1:0]  wr_idx;
    logic [ADDR_WIDTH:0]    count_d;

    logic                   result_valid_q, result_hit_q;
    logic [ADDR_WIDTH-1:0]  result_addr_q;
    logic [VALUE_WIDTH-1:0] result_value_q;
    logic                   learn_done_q, learn_hit_q, learn_drop_q;
    logic [ADDR_WIDTH:0]    entry_count_q;
    logic                   full_q;

`ifdef CAM_AGE_EN
    localparam int AGE_W = $clog2(AGE_MAX + 1);
    logic [AGE_W-1:0] age_q [DEPTH];

    always_comb begin
        expire = '0;
        for (int i = 0; i < DEPTH; i++)
            expire[i] = bus.age_tick && valid_q[i] && (age_q[i] == AGE_W'(1));
    end

    // A commit write to an entry overrides a coincident age decrement.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst)
                age_q[i] <= '0;
            else if (wr_en && wr_idx == ADDR_WIDTH'(i))
                age_q[i] <= AGE_W'(AGE_MAX);
            else if (bus.age_tick && valid_q[i] && age_q[i] > AGE_W'(1))
                age_q[i] <= age_q[i] - AGE_W'(1);
        end
    end
`else
    logic        unused_age_tick;
    logic [31:0] unused_age_max;
    assign expire          = '0;
    assign unused_age_tick = bus.age_tick;
    assign unused_age_max  = AGE_MAX;
`endif

    // Table as a commit would see it after this edge's aging and flush.
    assign valid_view = bus.flush ? '0 : (valid_q & ~expire);

    always_comb begin
        lk_hit      = 1'b0;
        lk_idx      = '0;
        ln_hit      = 1'b0;
        ln_hit_idx  = '0;
        ln_free     = 1'b0;
        ln_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && key_q[i] == bus.lookup_key) begin
                lk_hit = 1'b1;
                lk_idx = ADDR_WIDTH'(i);
            end
            if (valid_view[i] && key_q[i] == bus.learn_key) begin
                ln_hit     = 1'b1;
                ln_hit_idx = ADDR_WIDTH'(i);
            end
            if (!valid_view[i]) begin
                ln_free     = 1'b1;
                ln_free_idx = ADDR_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.learn_valid) begin
                    accept  = 1'b1;
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                commit  = !bus.flush;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_en  = commit && !rst && (cap_hit || cap_free);
    assign wr_idx = cap_hit ? cap_hit_idx : cap_free_idx;

    always_comb begin
        valid_d = valid_view;
        if (wr_en)
            valid_d[wr_idx] = 1'b1;
        count_d = '0;
        for (int i = 0; i < DEPTH; i++)
            count_d = count_d + (ADDR_WIDTH + 1)'(valid_d[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            valid_q        <= '0;
            entry_count_q  <= '0;
            full_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_hit_q   <= 1'b0;
            result_addr_q  <= '0;
            result_value_q <= '0;
            learn_done_q   <= 1'b0;
            learn_hit_q    <= 1'b0;
            learn_drop_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            valid_q        <= valid_d;
            entry_count_q  <= count_d;
            full_q         <= (count_d == (ADDR_WIDTH + 1)'(DEPTH));
            result_valid_q <= bus.lookup_valid;
            result_hit_q   <= bus.lookup_valid && lk_hit;
            result_addr_q  <= (bus.lookup_valid && lk_hit) ? lk_idx : '0;
            result_value_q <= (bus.lookup_valid && lk_hit) ? value_q[lk_idx] : '0;
            learn_done_q   <= commit;
            learn_hit_q    <= commit && cap_hit;
            learn_drop_q   <= commit && !cap_hit && !cap_free;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_key      <= bus.learn_key;
            cap_value    <= bus.learn_value;
            cap_hit      <= ln_hit;
            cap_hit_idx  <= ln_hit_idx;
            cap_free     <= ln_free;
            cap_free_idx <= ln_free_idx;
        end
        if (wr_en) begin
            key_q[wr_idx]   <= cap_key;
            value_q[wr_idx] <= cap_value;
        end
    end

    assign bus.learn_ready  = (state_q == S_IDLE) && !rst;
    assign bus.result_valid = result_valid_q;
    assign bus.result_hit   = result_hit_q;
    assign bus.result_addr  = result_addr_q;
    assign bus.result_value = result_value_q;
    assign bus.learn_done   = learn_done_q;
    assign bus.learn_hit    = learn_hit_q;
    assign bus.learn_drop   = learn_drop_q;
    assign bus.entry_count  = entry_count_q;
    assign bus.full         = full_q;
endmodule

// File: tb/tb_cam_learn_table.sv
// Directed scoreboard bench for cam_learn_table: lookup and learn outcomes are queued
// when driven and compared when the table reports them.
module tb_cam_learn_table;
    localparam int DW = 48;
    localparam int AW = 5;
    localparam int VW = 4;

    typedef struct {
        logic          hit;
        logic [AW-1:0] addr;
        logic [VW-1:0] value;
    } res_t;

    typedef struct {
        logic hit;
        logic drop;
    } lrn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    res_t rq[$];
    lrn_t lq[$];

    localparam logic [DW-1:0] KEY0 = 48'h001122334455;
    localparam logic [DW-1:0] KEYB = 48'h0B0000000042;
    localparam logic [DW-1:0] KEYC = 48'h0C00000000C3;
    localparam logic [DW-1:0] KEYA = 48'h0A0A0A0A0A0A;

    cam_learn_table_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VALUE_WIDTH(VW)) bus ();

    cam_learn_table #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .AGE_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        res_t r;
        lrn_t l;
        @(posedge clk);
        @(negedge clk);
        if (bus.result_valid === 1'b1) begin
            if (rq.size() == 0) begin
                chk("result_unexpected", 64'd1, 64'd0);
            end else begin
                r = rq.pop_front();
                chk("result_hit", bus.result_hit, r.hit);
                if (r.hit) begin
                    chk("result_addr", bus.result_addr, r.addr);
                    chk("result_value", bus.result_value, r.value);
                end
            end
        end
        if (bus.learn_done === 1'b1) begin
            if (lq.size() == 0) begin
                chk("learn_unexpected", 64'd1, 64'd0);
            end else begin
                l = lq.pop_front();
                chk("learn_hit", bus.learn_hit, l.hit);
                chk("learn_drop", bus.learn_drop, l.drop);
            end
        end
    endtask

    task automatic do_lookup(input logic [DW-1:0] key, input logic hit,
                             input logic [AW-1:0] addr, input logic [VW-1:0] value);
        bus.lookup_valid = 1'b1;
        bus.lookup_key   = key;
        rq.push_back('{hit, addr, value});
        tick();
        bus.lookup_valid = 1'b0;
        chk("lookup_pending", rq.size(), 0);
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 20 && bus.learn_ready !== 1'b1; n++) tick();
        chk("learn_ready_wait", bus.learn_ready, 1);
    endtask

    task automatic do_learn(input logic [DW-1:0] key, input logic [VW-1:0] value,
                            input logic hit, input logic drop);
        wait_ready();
        bus.learn_valid = 1'b1;
        bus.learn_key   = key;
        bus.learn_value = value;
        lq.push_back('{hit, drop});
        tick();
        bus.learn_valid = 1'b0;
        tick();
        chk("learn_pending", lq.size(), 0);
    endtask

    task automatic age_pulse();
        bus.age_tick = 1'b1;
        tick();
        bus.age_tick = 1'b0;
        tick();
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    initial begin
        bus.lookup_valid = 1'b0;
        bus.lookup_key   = '0;
        bus.learn_valid  = 1'b0;
        bus.learn_key    = '0;
        bus.learn_value  = '0;
        bus.age_tick     = 1'b0;
        bus.flush        = 1'b0;

        // reset, with a request held to prove rst dominates
        bus.lookup_valid = 1'b1;
        bus.learn_valid  = 1'b1;
        tick();
        tick();
        chk("rst_learn_ready", bus.learn_ready, 0);
        chk("rst_result_valid", bus.result_valid, 0);
        chk("rst_learn_done", bus.learn_done, 0);
        chk("rst_entry_count", bus.entry_count, 0);
        chk("rst_full", bus.full, 0);
        bus.lookup_valid = 1'b0;
        bus.learn_valid  = 1'b0;
        rst = 1'b0;
        tick();
        chk("ready_after_rst", bus.learn_ready, 1);

        // first learn, then refresh with a new value
        do_learn(KEY0, 4'd3, 1'b0, 1'b0);
        chk("count_after_learn", bus.entry_count, 1);
        do_lookup(KEY0, 1'b1, 5'd0, 4'd3);
        do_learn(KEY0, 4'd7, 1'b1, 1'b0);
        chk("count_after_refresh", bus.entry_count, 1);
        do_lookup(KEY0, 1'b1, 5'd0, 4'd7);

        // fill the remaining 31 slots, then overflow
        for (int i = 1; i < 32; i++) begin
            do_learn(48'h0D0000000000 + DW'(i), VW'(i), 1'b0, 1'b0);
        end
        chk("full_flag", bus.full, 1);
        chk("count_full", bus.entry_count, 32);
        do_lookup(48'h0D0000000011, 1'b1, 5'd17, 4'd1);
        do_lookup(48'h0D000000001F, 1'b1, 5'd31, 4'd15);
        do_learn(48'h0E0000000021, 4'd2, 1'b0, 1'b1);
        chk("count_after_drop", bus.entry_count, 32);
        do_lookup(48'h0E0000000021, 1'b0, 5'd0, 4'd0);

        do_flush();
        chk("count_after_flush", bus.entry_count, 0);
        chk("full_after_flush", bus.full, 0);
        do_lookup(KEY0, 1'b0, 5'd0, 4'd0);

        // back-to-back lookups across the commit edge of the same key
        bus.lookup_valid = 1'b1;
        bus.lookup_key   = KEYB;
        bus.learn_valid  = 1'b1;
        bus.learn_key    = KEYB;
        bus.learn_value  = 4'd5;
        rq.push_back('{1'b0, 5'd0, 4'd0});
        lq.push_back('{1'b0, 1'b0});
        tick();
        bus.learn_valid = 1'b0;
        rq.push_back('{1'b0, 5'd0, 4'd0});
        tick();
        rq.push_back('{1'b1, 5'd0, 4'd5});
        tick();
        rq.push_back('{1'b1, 5'd0, 4'd5});
        tick();
        bus.lookup_valid = 1'b0;
        chk("b2b_result_pending", rq.size(), 0);
        chk("b2b_learn_pending", lq.size(), 0);

        // flush while a learn is in COMMIT
        wait_ready();
        bus.learn_valid = 1'b1;
        bus.learn_key   = KEYC;
        bus.learn_value = 4'd9;
        tick();
        bus.learn_valid = 1'b0;
        bus.flush       = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("abort_learn_done", bus.learn_done, 0);
        chk("abort_entry_count", bus.entry_count, 0);
        chk("abort_learn_ready", bus.learn_ready, 1);
        do_lookup(KEYC, 1'b0, 5'd0, 4'd0);
        do_lookup(KEYB, 1'b0, 5'd0, 4'd0);

        // aging
        do_learn(KEYA, 4'd6, 1'b0, 1'b0);
        chk("age_count_start", bus.entry_count, 1);
        age_pulse();
        age_pulse();
        chk("age_count_two_ticks", bus.entry_count, 1);
        age_pulse();
`ifdef CAM_AGE_EN
        chk("age_count_expired", bus.entry_count, 0);
        do_lookup(KEYA, 1'b0, 5'd0, 4'd0);

        do_learn(KEYA, 4'd6, 1'b0, 1'b0);
        age_pulse();
        // relearn whose commit edge coincides with the second tick
        wait_ready();
        bus.learn_valid = 1'b1;
        bus.learn_key   = KEYA;
        bus.learn_value = 4'd8;
        lq.push_back('{1'b1, 1'b0});
        tick();
        bus.learn_valid = 1'b0;
        bus.age_tick    = 1'b1;
        tick();
        bus.age_tick = 1'b0;
        chk("relearn_pending", lq.size(), 0);
        age_pulse();
        age_pulse();
        chk("relearn_survives", bus.entry_count, 1);
        do_lookup(KEYA, 1'b1, 5'd0, 4'd8);
        age_pulse();
        chk("relearn_expired", bus.entry_count, 0);
`else
        chk("age_ignored_count", bus.entry_count, 1);
        age_pulse();
        chk("age_ignored_count2", bus.entry_count, 1);
        do_lookup(KEYA, 1'b1, 5'd0, 4'd6);
`endif

        tick();
        chk("final_result_pending", rq.size(), 0);
        chk("final_learn_pending", lq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
